mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data memory port between two requesters: the CPU load/store path (port 0) and a DMA/debug loader (port 1).
- The CPU has fixed priority. A starvation counter forces one DMA grant after DMA has waited MAX_WAIT consecutive cycles.
- The arbiter tracks the owner of each outstanding read and routes the 1-cycle-latency read data back to that requester.
- It sits between cpu memory signals, the loader and datamem. The CPU stalls on cpu_stall.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_WAIT, 4, consecutive blocked DMA cycles before DMA is forced a grant (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same as cpu_* for the DMA port
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_re

Behaviour:
- Handshake: same-cycle req/gnt. An access is accepted when req & gnt. A requester must hold req/we/addr/wdata stable until granted.
- Grant is combinational from req and the wait_cnt register. At most one gnt per cycle.
  - Only one requester: that one is granted.
  - Both requesting: CPU wins unless wait_cnt == MAX_WAIT, then DMA wins.
- Memory outputs for the accepted access:
  - mem_re = ~we; mem_we = we; address and write data from the winner.
  - No grant: mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
- wait_cnt:
  - Cleared to 0 when dma_gnt or ~dma_req.
  - Incremented, saturating at MAX_WAIT, when dma_req & ~dma_gnt.
  - Width is $clog2(MAX_WAIT+1).
- Read return:
  - On an accepted read, register rd_pend=1 and rd_owner = winner (0 CPU, 1 DMA).
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other port's rvalid=0 and rdata=0.
  - Back-to-back reads pipeline; rd_pend/rd_owner reload every cycle.
- Writes produce no rvalid.
- Reset (synchronous):
  - Clears wait_cnt=0, rd_pend=0, rd_owner=0.
  - While reset=1, all gnt, stall, mem strobes, rvalid and rdata are forced 0.
  - A read accepted the cycle before reset asserts never produces rvalid.
- Boundaries:
  - MAX_WAIT=1 yields CPU/DMA alternation under full contention.
  - Deasserting dma_req restarts the count from 0.
  - The CPU is never starved longer than 1 cycle per MAX_WAIT+1 window.

Optional Feature:
- MEM_ARB_PERF_EN defined: adds outputs perf_cpu_stall[15:0] and perf_dma_grants[15:0].
  - perf_cpu_stall counts cycles with cpu_stall=1; perf_dma_grants counts dma_gnt cycles.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic {OWN_CPU=1'b0, OWN_DMA=1'b1} owner_e.
  - Default constants ARB_ADDR_W=16, ARB_DATA_W=16, ARB_MAX_WAIT=4.
- One sub-module, arb_wait_counter: a saturating counter with inc, clr and sat outputs, parameterised by MAX_WAIT.
- Grant logic and read routing stay in the top module.

Test Plan:
- CPU-only read at 0x0010, mem_rdata=0xBEEF:
  - Same cycle: cpu_gnt=1, mem_re=1, mem_addr=0x0010.
  - Next cycle: cpu_rvalid=1, cpu_rdata=0xBEEF; dma_rvalid=0, dma_rdata=0.
- Both requesting reads continuously, MAX_WAIT=4:
  - CPU is granted cycles 0–3, DMA in cycle 4 (wait_cnt 4→0), CPU in cycle 5.
  - cpu_stall=1 only in cycle 4.
- DMA write 0x1234 to 0x0020, CPU idle:
  - dma_gnt=1, mem_we=1, mem_re=0, mem_wdata=0x1234.
  - No rvalid on either port the next cycle.
- CPU read 0x0002 in cycle 0, then DMA read 0x0003 in cycle 1, mem_rdata=0xAAAA then 0x5555:
  - cycle 1: cpu_rvalid, cpu_rdata=0xAAAA; dma_rvalid=0.
  - cycle 2: dma_rvalid, dma_rdata=0x5555; cpu_rvalid=0.
- CPU read accepted, then reset=1 the next cycle:
  - cpu_rvalid=0 in that cycle and after reset deasserts.
  - All gnt=0 while reset=1; wait_cnt=0 afterwards.
- Contention with dma_req high 2 cycles, low 1 cycle, then high again with CPU requesting:
  - DMA is not granted until 4 further blocked cycles.
  - With MEM_ARB_PERF_EN, perf_cpu_stall=1 and perf_dma_grants=1 at the end.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory port arbiter.
//   owner_e      : which requester owns an outstanding read (CPU or DMA)
//   ARB_ADDR_W   : default address width
//   ARB_DATA_W   : default data width
//   ARB_MAX_WAIT : default blocked-DMA cycles before a forced DMA grant
package mem_arb_pkg;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
    localparam int ARB_ADDR_W   = 16;
    localparam int ARB_DATA_W   = 16;
    localparam int ARB_MAX_WAIT = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating counter of consecutive blocked DMA cycles.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one more blocked cycle (holds at MAX_WAIT)
//   clr        : restart the count from 0 (takes precedence over inc)
//   sat        : count has reached MAX_WAIT
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] waitCnt;
    always_comb sat = waitCnt == CW'(MAX_WAIT);
    always_ff @(posedge clk) begin
        if (reset || clr)
            waitCnt <= '0;
        else if (inc && !sat)
            waitCnt <= waitCnt + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data memory port between the CPU (port 0, fixed
// priority) and a DMA/debug loader (port 1), with anti-starvation for DMA and
// 1-cycle read-data routing back to the requester that issued the read.
//   clk, reset           : clock, synchronous active-high reset
//   cpu_* / dma_*        : req/we/addr/wdata in, gnt/rvalid/rdata out; cpu_stall
//   mem_re/we/addr/wdata : memory command for the accepted access
//   mem_rdata            : memory read data, valid 1 cycle after mem_re
//   perf_cpu_stall, perf_dma_grants : saturating event counters, present only
//                          when MEM_ARB_PERF_EN is defined
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_cpu_stall,
    output logic [15:0]       perf_dma_grants
`endif
);
    logic   waitSat;
    logic   dmaWins;
    logic   rdPend;
    owner_e rdOwner;
    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) uWait (
        .clk  (clk),
        .reset(reset),
        .inc  (dma_req & ~dma_gnt),
        .clr  (dma_gnt | ~dma_req),
        .sat  (waitSat)
    );
    // DMA takes the port when alone, or when it has been blocked MAX_WAIT cycles.
    always_comb begin
        dmaWins    = dma_req & (~cpu_req | waitSat);
        dma_gnt    = ~reset & dmaWins;
        cpu_gnt    = ~reset & cpu_req & ~dmaWins;
        cpu_stall  = ~reset & cpu_req & ~cpu_gnt;
        mem_we     = dma_gnt ? dma_we  : cpu_gnt & cpu_we;
        mem_re     = dma_gnt ? ~dma_we : cpu_gnt & ~cpu_we;
        mem_addr   = dma_gnt ? dma_addr  : cpu_gnt ? cpu_addr  : '0;
        mem_wdata  = dma_gnt ? dma_wdata : cpu_gnt ? cpu_wdata : '0;
        cpu_rvalid = ~reset & rdPend & (rdOwner == OWN_CPU);
        dma_rvalid = ~reset & rdPend & (rdOwner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end
    // Reloaded every cycle so back-to-back reads pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPend  <= 1'b0;
            rdOwner <= OWN_CPU;
        end else begin
            rdPend  <= mem_re;
            rdOwner <= dma_gnt ? OWN_DMA : OWN_CPU;
        end
    end
`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cpu_stall  <= '0;
            perf_dma_grants <= '0;
        end else begin
            perf_cpu_stall  <= perf_cpu_stall  + {15'd0, cpu_stall & ~&perf_cpu_stall};
            perf_dma_grants <= perf_dma_grants + {15'd0, dma_gnt & ~&perf_dma_grants};
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (MAX_WAIT=4).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_re, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_cpu_stall, perf_dma_grants;
`endif
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_cpu_stall(perf_cpu_stall), .perf_dma_grants(perf_dma_grants)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpuDrive(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic dmaDrive(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
    endtask

    initial begin
        reset = 1'b1;
        mem_rdata = 16'h0;
        cpuDrive(1'b1, 1'b0, 16'h0001, 16'h0);
        dmaDrive(1'b1, 1'b0, 16'h0002, 16'h0);
        tick;
        @(negedge clk);
        checkVal("rst_cpu_gnt", cpu_gnt, 0);
        checkVal("rst_dma_gnt", dma_gnt, 0);
        checkVal("rst_stall", cpu_stall, 0);
        checkVal("rst_mem_re", mem_re, 0);
        checkVal("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
`ifdef MEM_ARB_PERF_EN
        checkVal("rst_perf_stall", perf_cpu_stall, 0);
        checkVal("rst_perf_dma", perf_dma_grants, 0);
`endif
        // CPU-only read
        tick;
        reset = 1'b0;
        cpuDrive(1'b1, 1'b0, 16'h0010, 16'h0);
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        checkVal("rd_cpu_gnt", cpu_gnt, 1);
        checkVal("rd_mem_re", mem_re, 1);
        checkVal("rd_mem_we", mem_we, 0);
        checkVal("rd_mem_addr", mem_addr, 32'h0010);
        checkVal("rd_stall", cpu_stall, 0);
        tick;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        checkVal("rd_cpu_rvalid", cpu_rvalid, 1);
        checkVal("rd_cpu_rdata", cpu_rdata, 32'hBEEF);
        checkVal("rd_dma_rvalid", dma_rvalid, 0);
        checkVal("rd_dma_rdata", dma_rdata, 0);
        checkVal("idle_mem_addr", mem_addr, 0);
        // Full contention: DMA forced in cycle 4
        for (int i = 0; i < 6; i++) begin
            tick;
            cpuDrive(1'b1, 1'b0, 16'h0100, 16'h0);
            dmaDrive(1'b1, 1'b0, 16'h0200, 16'h0);
            mem_rdata = 16'h1000 + 16'(i);
            @(negedge clk);
            checkVal($sformatf("ct%0d_cpu_gnt", i), cpu_gnt, (i == 4) ? 0 : 1);
            checkVal($sformatf("ct%0d_dma_gnt", i), dma_gnt, (i == 4) ? 1 : 0);
            checkVal($sformatf("ct%0d_stall", i), cpu_stall, (i == 4) ? 1 : 0);
            checkVal($sformatf("ct%0d_addr", i), mem_addr, (i == 4) ? 32'h0200 : 32'h0100);
            if (i > 0) begin
                checkVal($sformatf("ct%0d_dma_rv", i), dma_rvalid, (i == 5) ? 1 : 0);
                checkVal($sformatf("ct%0d_cpu_rd", i), cpu_rdata, (i == 5) ? 0 : 32'h1000 + i);
                checkVal($sformatf("ct%0d_dma_rd", i), dma_rdata, (i == 5) ? 32'h1005 : 0);
            end
        end
        tick;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        mem_rdata = 16'h7777;
        @(negedge clk);
        checkVal("ct_tail_cpu_rv", cpu_rvalid, 1);
        checkVal("ct_tail_cpu_rd", cpu_rdata, 32'h7777);
        // DMA write, CPU idle
        tick;
        dmaDrive(1'b1, 1'b1, 16'h0020, 16'h1234);
        @(negedge clk);
        checkVal("wr_dma_gnt", dma_gnt, 1);
        checkVal("wr_cpu_gnt", cpu_gnt, 0);
        checkVal("wr_mem_we", mem_we, 1);
        checkVal("wr_mem_re", mem_re, 0);
        checkVal("wr_mem_addr", mem_addr, 32'h0020);
        checkVal("wr_mem_wdata", mem_wdata, 32'h1234);
        tick;
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        checkVal("wr_no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        // CPU read then DMA read, routed to separate owners
        tick;
        cpuDrive(1'b1, 1'b0, 16'h0002, 16'h0);
        @(negedge clk);
        checkVal("p_cpu_gnt", cpu_gnt, 1);
        tick;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        dmaDrive(1'b1, 1'b0, 16'h0003, 16'h0);
        mem_rdata = 16'hAAAA;
        @(negedge clk);
        checkVal("p1_dma_gnt", dma_gnt, 1);
        checkVal("p1_addr", mem_addr, 32'h0003);
        checkVal("p1_cpu_rv", cpu_rvalid, 1);
        checkVal("p1_cpu_rd", cpu_rdata, 32'hAAAA);
        checkVal("p1_dma_rv", dma_rvalid, 0);
        tick;
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        mem_rdata = 16'h5555;
        @(negedge clk);
        checkVal("p2_dma_rv", dma_rvalid, 1);
        checkVal("p2_dma_rd", dma_rdata, 32'h5555);
        checkVal("p2_cpu_rv", cpu_rvalid, 0);
        checkVal("p2_cpu_rd", cpu_rdata, 0);
        // Read accepted, then reset
        tick;
        cpuDrive(1'b1, 1'b0, 16'h0004, 16'h0);
        @(negedge clk);
        checkVal("r_cpu_gnt", cpu_gnt, 1);
        tick;
        reset = 1'b1;
        dmaDrive(1'b1, 1'b0, 16'h0005, 16'h0);
        mem_rdata = 16'h9999;
        @(negedge clk);
        checkVal("r_in_rst_rv", cpu_rvalid, 0);
        checkVal("r_in_rst_rd", cpu_rdata, 0);
        checkVal("r_in_rst_gnt", {cpu_gnt, dma_gnt}, 0);
        checkVal("r_in_rst_stall", cpu_stall, 0);
        tick;
        reset = 1'b0;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        checkVal("r_after_rv", {cpu_rvalid, dma_rvalid}, 0);
        // DMA drops request mid-wait: count restarts from 0
        for (int i = 0; i < 8; i++) begin
            tick;
            cpuDrive(1'b1, 1'b0, 16'h0040, 16'h0);
            dmaDrive(i != 2, 1'b0, 16'h0050, 16'h0);
            @(negedge clk);
            checkVal($sformatf("dr%0d_dma_gnt", i), dma_gnt, (i == 7) ? 1 : 0);
            checkVal($sformatf("dr%0d_stall", i), cpu_stall, (i == 7) ? 1 : 0);
        end
        tick;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        dmaDrive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        checkVal("dr_tail_dma_rv", dma_rvalid, 1);
`ifdef MEM_ARB_PERF_EN
        checkVal("perf_stall", perf_cpu_stall, 1);
        checkVal("perf_dma", perf_dma_grants, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
